rr_grant_responder: RTL and testbench
=====================================

// Module: rr_grant_responder
// PURPOSE
//  Downstream consumer of the round-robin arbiter winner. Latches the winning index when
//  Data_Valid, drives a one-hot grant to that requester, accepts its burst of beats, and
//  pulses Arbitration_ack so the arbiter may advance. Holds ownership stable until ack.
// PARAMETERS
//  N_REQ      4    number of requesters (one-hot grant width)
//  IDX_W      2    winner index width, clog2(N_REQ)
//  BEAT_W     4    burst length field width per requester
//  TIMEOUT    16   max consecutive GRANT cycles without an accepted beat, >=2
// PORTS
//  clk              in   1             single clock, all state on posedge
//  rst              in   1             synchronous, active-low reset
//  Next_priority    in   IDX_W         winner index from arbiter
//  Data_Valid       in   1             winner index valid
//  Req_len          in   N_REQ*BEAT_W  burst length per requester, slice i = [i*BEAT_W +: BEAT_W]
//  Beat_valid       in   1             granted requester presents a beat
//  Beat_ready       out  1             responder accepts beat (beat = valid & ready)
//  Grant            out  N_REQ         one-hot grant to current owner, 0 when none
//  Owner            out  IDX_W         latched owner index
//  Busy             out  1             high in GRANT and ACK
//  Arbitration_ack  out  1             one-cycle pulse: arbitration consumed
//  Timeout_err      out  1             one-cycle pulse coincident with a timeout-forced ack
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; Grant=0, Owner=0, Busy=0, Beat_ready=0,
//    Arbitration_ack=0, Timeout_err=0, beat count=0, timer=0. Overrides everything, any state.
//  - FSM IDLE -> GRANT -> ACK -> IDLE. All outputs are functions of registered state only.
//  - IDLE: if Data_Valid at posedge: Owner<=Next_priority; cnt<=Req_len[Owner] (0 -> 1);
//    timer<=0; go GRANT. Grant=onehot(Owner) from the next cycle (latency 1). Else stay.
//  - GRANT: Busy=1, Beat_ready=1, Grant=onehot(Owner). Data_Valid/Next_priority ignored.
//    Beat accepted: cnt<=cnt-1, timer<=0; if cnt==1 -> ACK.
//    No beat: timer<=timer+1; if timer==TIMEOUT-1 -> ACK with Timeout_err flagged.
//    Beat on the timeout cycle: beat wins, no error.
//  - ACK (exactly one cycle): Arbitration_ack=1, Grant=0, Beat_ready=0, Busy=1,
//    Timeout_err=1 iff entered by timeout. Next state IDLE unconditionally.
//  - After ACK, IDLE lasts >=1 cycle so the arbiter's updated winner is sampled, never stale.
//  - Owner holds its value through IDLE until the next capture.
//  - Req_len sampled only at capture; later changes do not affect the burst in progress.
//  - Widths: cnt is BEAT_W bits; timer is clog2(TIMEOUT) bits, no wrap (saturates into ACK).
// STRUCTURE
//  - Shared header rr_defs.vh: state encodings (IDLE=2'd0, GRANT=2'd1, ACK=2'd2),
//    N_REQ/IDX_W defaults, onehot(idx) function. Shared with the arbiter.
//  - One sub-module: rr_beat_counter. Loads len (0 -> 1), decrements on beat, runs the
//    timeout timer, outputs last_beat and timed_out. FSM and output regs stay in top.
//  - Grant decode and state register in the top; ~120-250 lines total.
// TESTING
//  1 Reset: rst=0 for 2 cycles, Data_Valid=1 -> all outputs 0, state IDLE; release -> capture.
//  2 Basic: Next_priority=2, Data_Valid=1, Req_len[2]=3, Beat_valid=1 -> Grant=4'b0100
//    for 3 cycles, then Arbitration_ack=1 one cycle, Timeout_err=0, Grant=0.
//  3 Zero length: Req_len[1]=0, winner 1 -> exactly one beat accepted, then ack.
//  4 Timeout: winner 3, Req_len[3]=4, Beat_valid=0 -> ack + Timeout_err on the 17th cycle
//    after capture (16 GRANT cycles); one beat at GRANT cycle 10 restarts the count.
//  5 Back-to-back: Data_Valid held, winner 1 then 3 after ack -> Grant 0010 then 1000,
//    exactly one IDLE cycle between them, Owner updates 1 -> 3.
//  6 Reset mid-burst: rst=0 after 1 of 4 beats -> Grant=0 next cycle, no ack ever issued.

Source files
------------

// File: rtl/rr_grant_responder_pkg.sv
// Shared definitions for the round-robin grant responder.
// Contents: FSM state encodings, default requester geometry, the counter
// status payload passed from the beat counter to the FSM, and a one-hot
// decode helper shared with the arbiter side.
package rr_grant_responder_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned IDX_W_DEF    = 2;
    localparam int unsigned ONEHOT_MAX   = 32;
    localparam int unsigned ONEHOT_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Burst progress flags, decoded from the counter's registered state.
    typedef struct packed {
        logic last_beat;
        logic timed_out;
    } cnt_status_t;

    // One-hot decode of an index; callers truncate to their own width.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx);
        logic [ONEHOT_MAX-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_responder_beat_counter.sv
// Burst beat counter and idle-grant timeout timer.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load          capture a new burst length (0 is treated as 1), clear timer
//   len           burst length to load
//   beat          a beat was accepted this cycle
//   idle_tick     owner is granted but presented no beat this cycle
//   status_c      last_beat (one beat remaining) / timed_out (timer at limit)
module rr_grant_responder_beat_counter
    import rr_grant_responder_pkg::*;
#(
    parameter int unsigned BEAT_W  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] len,
    input  logic              beat,
    input  logic              idle_tick,
    output cnt_status_t       status_c
);

    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [BEAT_W-1:0] cnt_q;
    logic [TMR_W-1:0]  tmr_q;

    // Remaining-beat count and consecutive idle-grant timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            tmr_q <= '0;
        end else if (load) begin
            cnt_q <= (len == '0) ? BEAT_W'(1) : len;
            tmr_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q - BEAT_W'(1);
            tmr_q <= '0;
        end else if (idle_tick && !status_c.timed_out) begin
            // Saturates at the limit; the FSM leaves GRANT on that same edge.
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    assign status_c.last_beat = (cnt_q == BEAT_W'(1));
    assign status_c.timed_out = (tmr_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/rr_grant_responder.sv
// Downstream consumer of the round-robin arbiter winner. Captures the winning
// index, grants that requester one-hot, accepts its burst, then pulses
// Arbitration_ack for one cycle so the arbiter may advance. A requester that
// stalls for TIMEOUT consecutive grant cycles is dropped with Timeout_err.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   Next_priority    winner index from the arbiter
//   Data_Valid       winner index valid
//   Req_len          per-requester burst lengths, slice i = [i*BEAT_W +: BEAT_W]
//   Beat_valid       granted requester presents a beat
//   Beat_ready       responder accepts a beat (high in GRANT)
//   Grant            one-hot grant to the current owner, 0 outside GRANT
//   Owner            latched owner index, held until the next capture
//   Busy             high in GRANT and ACK
//   Arbitration_ack  one-cycle pulse, arbitration consumed
//   Timeout_err      one-cycle pulse alongside a timeout-forced ack
module rr_grant_responder
    import rr_grant_responder_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned BEAT_W  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        Next_priority,
    input  logic                    Data_Valid,
    input  logic [N_REQ*BEAT_W-1:0] Req_len,
    input  logic                    Beat_valid,
    output logic                    Beat_ready,
    output logic [N_REQ-1:0]        Grant,
    output logic [IDX_W-1:0]        Owner,
    output logic                    Busy,
    output logic                    Arbitration_ack,
    output logic                    Timeout_err
);

    state_e            state_q;
    state_e            state_d;
    logic [IDX_W-1:0]  owner_d;
    logic              tmo_d;
    logic [N_REQ-1:0]  grant_d;
    logic              busy_d;
    logic              ready_d;
    logic              ack_d;
    logic              terr_d;

    logic              in_grant;
    logic              beat;
    logic              load;
    logic              idle_tick;
    logic [BEAT_W-1:0] len_sel;
    cnt_status_t       cnt_status;

    assign in_grant  = (state_q == ST_GRANT);
    assign beat      = in_grant & Beat_valid;
    assign idle_tick = in_grant & ~Beat_valid;
    assign load      = (state_q == ST_IDLE) & Data_Valid;

    // Burst length of the incoming winner; only consumed on capture.
    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (Next_priority == IDX_W'(i)) begin
                len_sel = Req_len[i*BEAT_W +: BEAT_W];
            end
        end
    end

    rr_grant_responder_beat_counter #(
        .BEAT_W  (BEAT_W),
        .TIMEOUT (TIMEOUT)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .len       (len_sel),
        .beat      (beat),
        .idle_tick (idle_tick),
        .status_c  (cnt_status)
    );

    // Next state, next owner, and next registered output values.
    always_comb begin
        state_d = state_q;
        owner_d = Owner;
        tmo_d   = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        terr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_d = ST_GRANT;
                    owner_d = Next_priority;
                end
            end
            ST_GRANT: begin
                // An accepted beat always beats the timeout on the same cycle.
                if (beat) begin
                    if (cnt_status.last_beat) begin
                        state_d = ST_ACK;
                    end
                end else if (cnt_status.timed_out) begin
                    state_d = ST_ACK;
                    tmo_d   = 1'b1;
                end
            end
            ST_ACK: begin
                // Always return through IDLE so a fresh winner is sampled.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_GRANT: begin
                grant_d = N_REQ'(onehot(ONEHOT_IDX_W'(owner_d)));
                busy_d  = 1'b1;
                ready_d = 1'b1;
            end
            ST_ACK: begin
                busy_d = 1'b1;
                ack_d  = 1'b1;
                terr_d = tmo_d;
            end
            default: begin
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            Owner           <= '0;
            Grant           <= '0;
            Busy            <= 1'b0;
            Beat_ready      <= 1'b0;
            Arbitration_ack <= 1'b0;
            Timeout_err     <= 1'b0;
        end else begin
            state_q         <= state_d;
            Owner           <= owner_d;
            Grant           <= grant_d;
            Busy            <= busy_d;
            Beat_ready      <= ready_d;
            Arbitration_ack <= ack_d;
            Timeout_err     <= terr_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_responder.sv
// Directed bench for rr_grant_responder with a burst scoreboard: every capture
// pushes the expected owner, beat count and timeout flag; a negedge monitor
// counts accepted beats and pops/compares on each Arbitration_ack.
module tb_rr_grant_responder;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BEAT_W  = 4;
    localparam int unsigned TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [IDX_W-1:0]        Next_priority;
    logic                    Data_Valid;
    logic [N_REQ*BEAT_W-1:0] Req_len;
    logic                    Beat_valid;
    logic                    Beat_ready;
    logic [N_REQ-1:0]        Grant;
    logic [IDX_W-1:0]        Owner;
    logic                    Busy;
    logic                    Arbitration_ack;
    logic                    Timeout_err;

    rr_grant_responder #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .BEAT_W  (BEAT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Next_priority   (Next_priority),
        .Data_Valid      (Data_Valid),
        .Req_len         (Req_len),
        .Beat_valid      (Beat_valid),
        .Beat_ready      (Beat_ready),
        .Grant           (Grant),
        .Owner           (Owner),
        .Busy            (Busy),
        .Arbitration_ack (Arbitration_ack),
        .Timeout_err     (Timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int beats;
        bit tmo;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   beat_seen = 0;
    int   errors    = 0;
    int   checks    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int idx, input int len);
        Req_len[idx*BEAT_W +: BEAT_W] = BEAT_W'(len);
    endtask

    function automatic logic [N_REQ-1:0] oh(input int i);
        return N_REQ'(1 << i);
    endfunction

    // Ticks until Arbitration_ack is seen or the bound expires.
    task automatic wait_ack(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!Arbitration_ack && n < bound);
        chk("ack_seen", 32'(Arbitration_ack), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            beat_seen = 0;
        end else begin
            if (Beat_valid && Beat_ready) begin
                beat_seen++;
                chk("sb_beat_has_burst", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("sb_beat_grant", 32'(Grant), 32'(oh(sb[0].owner)));
                end
            end
            if (Arbitration_ack) begin
                chk("sb_ack_has_burst", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("sb_owner", 32'(Owner), 32'(e_mon.owner));
                    chk("sb_beats", 32'(beat_seen), 32'(e_mon.beats));
                    chk("sb_timeout", 32'(Timeout_err), 32'(e_mon.tmo));
                    chk("sb_ack_grant0", 32'(Grant), 32'd0);
                end
                beat_seen = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saw_ack;

        // Reset held with a valid winner present.
        rst           = 1'b0;
        Data_Valid    = 1'b1;
        Next_priority = 2'd2;
        Req_len       = '0;
        Beat_valid    = 1'b1;
        tick();
        tick();
        chk("rst_grant",  32'(Grant), 32'd0);
        chk("rst_owner",  32'(Owner), 32'd0);
        chk("rst_busy",   32'(Busy), 32'd0);
        chk("rst_ready",  32'(Beat_ready), 32'd0);
        chk("rst_ack",    32'(Arbitration_ack), 32'd0);
        chk("rst_terr",   32'(Timeout_err), 32'd0);

        // Release: capture winner 0 with a 2-beat burst.
        Next_priority = 2'd0;
        set_len(0, 2);
        rst = 1'b1;
        sb.push_back('{0, 2, 1'b0});
        tick();
        chk("t1_grant", 32'(Grant), 32'(oh(0)));
        chk("t1_busy",  32'(Busy), 32'd1);
        Data_Valid = 1'b0;
        wait_ack(8, n);
        chk("t1_ack_latency", 32'(n), 32'd2);
        tick();
        chk("t1_ack_one_cycle", 32'(Arbitration_ack), 32'd0);
        chk("t1_idle_busy",     32'(Busy), 32'd0);

        // Basic 3-beat burst to requester 2.
        Next_priority = 2'd2;
        set_len(2, 3);
        Data_Valid = 1'b1;
        sb.push_back('{2, 3, 1'b0});
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_grant",  32'(Grant), 32'(4'b0100));
            chk("t2_no_ack", 32'(Arbitration_ack), 32'd0);
            tick();
        end
        chk("t2_ack",   32'(Arbitration_ack), 32'd1);
        chk("t2_terr",  32'(Timeout_err), 32'd0);
        chk("t2_grant0", 32'(Grant), 32'd0);
        chk("t2_ready0", 32'(Beat_ready), 32'd0);
        chk("t2_busy",  32'(Busy), 32'd1);
        tick();
        chk("t2_idle_ack",  32'(Arbitration_ack), 32'd0);
        chk("t2_idle_busy", 32'(Busy), 32'd0);
        chk("t2_owner_hold", 32'(Owner), 32'd2);

        // Zero length is one beat.
        Next_priority = 2'd1;
        set_len(1, 0);
        Data_Valid = 1'b1;
        sb.push_back('{1, 1, 1'b0});
        tick();
        Data_Valid = 1'b0;
        chk("t3_grant", 32'(Grant), 32'(4'b0010));
        tick();
        chk("t3_ack", 32'(Arbitration_ack), 32'd1);
        tick();

        // Timeout with no beats: ack on the 16th edge after capture.
        Beat_valid    = 1'b0;
        Next_priority = 2'd3;
        set_len(3, 4);
        Data_Valid = 1'b1;
        sb.push_back('{3, 0, 1'b1});
        tick();
        Data_Valid = 1'b0;
        chk("t4_grant", 32'(Grant), 32'(4'b1000));
        wait_ack(40, n);
        chk("t4_timeout_latency", 32'(n), 32'd16);
        chk("t4_terr", 32'(Timeout_err), 32'd1);
        tick();
        chk("t4_terr_pulse", 32'(Timeout_err), 32'd0);

        // A beat at grant cycle 10 restarts the idle count.
        Data_Valid = 1'b1;
        sb.push_back('{3, 1, 1'b1});
        tick();
        Data_Valid = 1'b0;
        repeat (9) tick();
        chk("t4b_no_early_ack", 32'(Arbitration_ack), 32'd0);
        Beat_valid = 1'b1;
        tick();
        Beat_valid = 1'b0;
        wait_ack(40, n);
        chk("t4b_restart_latency", 32'(n), 32'd16);
        chk("t4b_terr", 32'(Timeout_err), 32'd1);
        tick();

        // Back-to-back with Data_Valid held: winner 1 then 3.
        Beat_valid    = 1'b1;
        Next_priority = 2'd1;
        set_len(1, 1);
        set_len(3, 2);
        Data_Valid = 1'b1;
        sb.push_back('{1, 1, 1'b0});
        tick();
        chk("t5_grant_a", 32'(Grant), 32'(4'b0010));
        chk("t5_owner_a", 32'(Owner), 32'd1);
        tick();
        chk("t5_ack_a", 32'(Arbitration_ack), 32'd1);
        Next_priority = 2'd3;
        sb.push_back('{3, 2, 1'b0});
        tick();
        chk("t5_gap_grant", 32'(Grant), 32'd0);
        chk("t5_gap_busy",  32'(Busy), 32'd0);
        chk("t5_gap_owner", 32'(Owner), 32'd1);
        tick();
        chk("t5_grant_b", 32'(Grant), 32'(4'b1000));
        chk("t5_owner_b", 32'(Owner), 32'd3);
        Data_Valid = 1'b0;
        set_len(3, 9);
        wait_ack(20, n);
        chk("t5_len_sampled_once", 32'(n), 32'd2);
        tick();

        // Reset after one of four beats.
        Next_priority = 2'd0;
        set_len(0, 4);
        Data_Valid = 1'b1;
        sb.push_back('{0, 4, 1'b0});
        tick();
        Data_Valid = 1'b0;
        chk("t6_grant", 32'(Grant), 32'(4'b0001));
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("t6_rst_grant", 32'(Grant), 32'd0);
        chk("t6_rst_busy",  32'(Busy), 32'd0);
        chk("t6_rst_ready", 32'(Beat_ready), 32'd0);
        chk("t6_rst_ack",   32'(Arbitration_ack), 32'd0);
        chk("t6_rst_owner", 32'(Owner), 32'd0);
        rst = 1'b1;
        saw_ack = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (Arbitration_ack) saw_ack = 1;
        end
        chk("t6_no_ack_after_reset", 32'(saw_ack), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
